// File: rtl/reg_wb_queue.sv
// reg_wb_queue: write-back FIFO between execute and the reg_general bank.
// Requests (addr,data) are queued and drained one per cycle as a registered
// one-hot load strobe plus data. Pending writes are forwarded newest-first
// to operand read logic.
module reg_wb_queue #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      in_ready,
    input  logic                      hold,
    output logic [NUM_REGS-1:0]       ld_en,
    output logic [DATA_W-1:0]         wr_data,
    output logic [$clog2(DEPTH):0]    count,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic                      fwd_hit,
    output logic [DATA_W-1:0]         fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              push;
    logic              pop;

    assign in_ready = (count < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && !hold;

    // Queue storage; validity is tracked solely by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= in_addr;
            mem_data[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output stage: one-cycle one-hot strobe per popped entry; data holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_en   <= '0;
            wr_data <= '0;
        end else if (pop) begin
            ld_en   <= NUM_REGS'(1) << mem_addr[rd_ptr];
            wr_data <= mem_data[rd_ptr];
        end else begin
            ld_en   <= '0;
        end
    end

    // Forwarding: output stage is lowest priority; scanning the queue oldest
    // to newest lets later (newer) matches overwrite earlier ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (ld_en[rd_addr]) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (mem_addr[idx] == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data[idx];
            end
        end
    end

endmodule
